// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared state encodings, master indices and default arbiter settings.
package bus_arbiter_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    GRANT  = 3'b010,
    SWITCH = 3'b100
  } state_t;
  localparam int         CORE_IDX      = 0;
  localparam int         UART_DBG_IDX  = 1;
  localparam int         JTAG_IDX      = 2;
  localparam int         DEF_N_MASTERS = 3;
  localparam logic [2:0] DEF_PRIO_MASK = 3'b110;
  localparam int         DEF_MAX_BURST = 16;
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// bus_arbiter_rr_pick: combinational winner pick; masked requesters first (lowest index),
// otherwise the first requester at or after ptr, searching cyclically.
module bus_arbiter_rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_mask,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_win,
  output logic          o_valid
);
  logic [N-1:0] w_pri;
  logic         w_hit;
  assign w_pri   = i_req & i_mask;
  assign o_valid = |i_req;
  // Cyclic search = first requester at/after ptr, else first requester overall.
  always_comb begin
    o_win = '0;
    w_hit = 1'b0;
    for (int i = 0; i < N; i++)
      if (!w_hit && w_pri[i]) begin
        o_win[i] = 1'b1;
        w_hit    = 1'b1;
      end
    for (int i = 0; i < N; i++)
      if (!w_hit && i_req[i] && i >= int'(i_ptr)) begin
        o_win[i] = 1'b1;
        w_hit    = 1'b1;
      end
    for (int i = 0; i < N; i++)
      if (!w_hit && i_req[i]) begin
        o_win[i] = 1'b1;
        w_hit    = 1'b1;
      end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: registered round-robin grant with priority pre-emption and burst limit,
// muxing the owning master onto a single-cycle bus.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int                   N_MASTERS = DEF_N_MASTERS,
  parameter logic [N_MASTERS-1:0] PRIO_MASK = DEF_PRIO_MASK,
  parameter int                   MAX_BURST = DEF_MAX_BURST
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_MASTERS-1:0]    m_req_i,
  input  logic [N_MASTERS-1:0]    m_we_i,
  input  logic [32*N_MASTERS-1:0] m_addr_i,
  input  logic [32*N_MASTERS-1:0] m_wdata_i,
  output logic [N_MASTERS-1:0]    m_gnt_o,
  output logic [31:0]             m_rdata_o,
  output logic                    s_rd_o,
  output logic                    s_we_o,
  output logic [31:0]             s_addr_o,
  output logic [31:0]             s_wdata_o,
  input  logic [31:0]             s_rdata_i,
  output logic                    hold_flag_o
);
  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  state_t                 r_state, w_state_n;
  logic [N_MASTERS-1:0]   r_gnt, w_gnt_n, w_win;
  logic [PW-1:0]          r_ptr, w_ptr_n, w_nptr;
  logic [7:0]             r_cnt, w_cnt_n;
  logic [31:0]            r_addr, r_wdata, w_addr_mux, w_wdata_mux;
  logic                   w_valid, w_own, w_req_g, w_we_g, w_others, w_pre, w_lim;
  bus_arbiter_rr_pick #(.N(N_MASTERS), .PW(PW)) u_pick (
    .i_req   (m_req_i),
    .i_mask  (PRIO_MASK),
    .i_ptr   (r_ptr),
    .o_win   (w_win),
    .o_valid (w_valid)
  );
  always_comb begin
    w_addr_mux  = '0;
    w_wdata_mux = '0;
    w_req_g     = 1'b0;
    w_we_g      = 1'b0;
    w_nptr      = '0;
    for (int i = 0; i < N_MASTERS; i++)
      if (r_gnt[i]) begin
        w_addr_mux  = m_addr_i[32*i +: 32];
        w_wdata_mux = m_wdata_i[32*i +: 32];
        w_req_g     = m_req_i[i];
        w_we_g      = m_we_i[i];
        w_nptr      = (i == N_MASTERS-1) ? '0 : PW'(i + 1);
      end
  end
  assign w_own       = r_state == GRANT;
  assign w_others    = |(m_req_i & ~r_gnt);
  assign w_pre       = ~|(r_gnt & PRIO_MASK) & |(m_req_i & PRIO_MASK);
  assign w_lim       = w_others & (r_cnt == 8'(MAX_BURST - 1));
  assign s_rd_o      = w_own & w_req_g & ~w_we_g;
  assign s_we_o      = w_own & w_req_g & w_we_g;
  // Address/data hold their last owner value through SWITCH and IDLE.
  assign s_addr_o    = w_own ? w_addr_mux : r_addr;
  assign s_wdata_o   = w_own ? w_wdata_mux : r_wdata;
  assign m_gnt_o     = r_gnt;
  assign m_rdata_o   = s_rdata_i;
  assign hold_flag_o = m_req_i[CORE_IDX] & ~r_gnt[CORE_IDX];
  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
    if (w_own) begin
      if (!w_req_g || w_lim || w_pre) begin
        w_state_n = SWITCH;
        w_gnt_n   = '0;
        w_ptr_n   = w_nptr;
        w_cnt_n   = '0;
      end else
        w_cnt_n = !w_others ? '0 : (r_cnt == 8'(MAX_BURST)) ? r_cnt : r_cnt + 8'd1;
    end else begin
      w_state_n = w_valid ? GRANT : IDLE;
      w_gnt_n   = w_win;
      w_cnt_n   = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_ptr   <= w_ptr_n;
      r_cnt   <= w_cnt_n;
      if (w_own) begin
        r_addr  <= w_addr_mux;
        r_wdata <= w_wdata_mux;
      end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of a default arbiter (a_*) and a PRIO_MASK=0, MAX_BURST=4 one (b_*).
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0, we = '0;
  logic [95:0] addr = '0, wdata = '0;
  logic [31:0] rdata_in = '0;
  logic [2:0]  a_gnt, b_gnt;
  logic [31:0] a_rdata, a_addr, a_wdata, b_rdata, b_addr, b_wdata;
  logic        a_rd, a_we, a_hold, b_rd, b_we, b_hold;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  bus_arbiter dut_a (
    .clk(clk), .rst_n(rst_n), .m_req_i(req), .m_we_i(we), .m_addr_i(addr), .m_wdata_i(wdata),
    .m_gnt_o(a_gnt), .m_rdata_o(a_rdata), .s_rd_o(a_rd), .s_we_o(a_we), .s_addr_o(a_addr),
    .s_wdata_o(a_wdata), .s_rdata_i(rdata_in), .hold_flag_o(a_hold)
  );
  bus_arbiter #(.PRIO_MASK(3'b000), .MAX_BURST(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .m_req_i(req), .m_we_i(we), .m_addr_i(addr), .m_wdata_i(wdata),
    .m_gnt_o(b_gnt), .m_rdata_o(b_rdata), .s_rd_o(b_rd), .s_we_o(b_we), .s_addr_o(b_addr),
    .s_wdata_o(b_wdata), .s_rdata_i(rdata_in), .hold_flag_o(b_hold)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    req = '0;
    we = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++; if (a_gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b exp=000", a_gnt); end
    total++; if ({a_rd, a_we} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {a_rd, a_we}); end
    total++; if (a_addr !== 32'h0 || a_wdata !== 32'h0) begin bad++; $display("FAIL reset_bus got=%h/%h exp=0/0", a_addr, a_wdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req = 3'b001;
    addr[31:0] = 32'h0000_0010;
    rdata_in = 32'h0000_CAFE;
    #1;
    total++; if (a_gnt !== 3'b000 || a_hold !== 1'b1) begin bad++; $display("FAIL single_pre got=%b/%b exp=000/1", a_gnt, a_hold); end
    step();
    total++; if (a_gnt !== 3'b001) begin bad++; $display("FAIL single_gnt got=%b exp=001", a_gnt); end
    total++; if (a_rd !== 1'b1 || a_we !== 1'b0) begin bad++; $display("FAIL single_rd got=%b%b exp=10", a_rd, a_we); end
    total++; if (a_addr !== 32'h10) begin bad++; $display("FAIL single_addr got=%h exp=00000010", a_addr); end
    total++; if (a_hold !== 1'b0) begin bad++; $display("FAIL single_hold got=%b exp=0", a_hold); end
    total++; if (a_rdata !== 32'h0000_CAFE) begin bad++; $display("FAIL single_rdata got=%h exp=0000cafe", a_rdata); end
    step();
    total++; if (a_gnt !== 3'b001) begin bad++; $display("FAIL single_keep got=%b exp=001", a_gnt); end
    req = 3'b000;
    step();
    total++; if (a_gnt !== 3'b000 || a_rd !== 1'b0) begin bad++; $display("FAIL single_switch got=%b/%b exp=000/0", a_gnt, a_rd); end
    total++; if (a_addr !== 32'h10) begin bad++; $display("FAIL single_addr_hold got=%h exp=00000010", a_addr); end
    step();
    total++; if (a_gnt !== 3'b000) begin bad++; $display("FAIL single_idle got=%b exp=000", a_gnt); end
  endtask

  task automatic test_preempt();
    do_reset();
    req = 3'b001;
    addr[31:0] = 32'h20;
    addr[63:32] = 32'h40;
    step();
    total++; if (a_gnt !== 3'b001) begin bad++; $display("FAIL pre_core got=%b exp=001", a_gnt); end
    req = 3'b011;
    #1;
    total++; if (a_gnt !== 3'b001 || a_hold !== 1'b0) begin bad++; $display("FAIL pre_same got=%b/%b exp=001/0", a_gnt, a_hold); end
    step();
    total++; if (a_gnt !== 3'b000 || {a_rd, a_we} !== 2'b00 || a_hold !== 1'b1) begin bad++; $display("FAIL pre_switch got=%b/%b%b/%b exp=000/00/1", a_gnt, a_rd, a_we, a_hold); end
    step();
    total++; if (a_gnt !== 3'b010 || a_hold !== 1'b1) begin bad++; $display("FAIL pre_uart got=%b/%b exp=010/1", a_gnt, a_hold); end
    total++; if (a_addr !== 32'h40) begin bad++; $display("FAIL pre_addr got=%h exp=00000040", a_addr); end
    req = 3'b001;
    step();
    total++; if (a_gnt !== 3'b000 || a_hold !== 1'b1) begin bad++; $display("FAIL pre_release got=%b/%b exp=000/1", a_gnt, a_hold); end
    step();
    total++; if (a_gnt !== 3'b001 || a_hold !== 1'b0) begin bad++; $display("FAIL pre_back got=%b/%b exp=001/0", a_gnt, a_hold); end
    req = 3'b000;
    step();
    step();
  endtask

  task automatic test_burst();
    logic [2:0] exp;
    do_reset();
    req = 3'b101;
    for (int i = 0; i < 20; i++) begin
      step();
      exp = (i % 10 < 4) ? 3'b001 : (i % 10 == 4 || i % 10 == 9) ? 3'b000 : 3'b100;
      total++; if (b_gnt !== exp) begin bad++; $display("FAIL burst_gnt[%0d] got=%b exp=%b", i, b_gnt, exp); end
      total++; if (b_hold !== (exp != 3'b001)) begin bad++; $display("FAIL burst_hold[%0d] got=%b exp=%b", i, b_hold, exp != 3'b001); end
    end
    req = 3'b000;
    step();
    step();
  endtask

  task automatic test_rr();
    int ord [4] = '{0, 1, 2, 0};
    logic [2:0] exp;
    do_reset();
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      exp = 3'b001 << ord[k];
      step();
      total++; if (b_gnt !== exp) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, b_gnt, exp); end
      step();
      total++; if (b_gnt !== exp) begin bad++; $display("FAIL rr_keep[%0d] got=%b exp=%b", k, b_gnt, exp); end
      req[ord[k]] = 1'b0;
      step();
      total++; if (b_gnt !== 3'b000) begin bad++; $display("FAIL rr_dead[%0d] got=%b exp=000", k, b_gnt); end
      req[ord[k]] = 1'b1;
    end
    req = 3'b000;
    step();
    step();
  endtask

  task automatic test_write();
    do_reset();
    req = 3'b010;
    we = 3'b010;
    addr[63:32] = 32'h3000_0008;
    wdata[63:32] = 32'h0000_01B8;
    step();
    total++; if (a_gnt !== 3'b010) begin bad++; $display("FAIL wr_gnt got=%b exp=010", a_gnt); end
    total++; if (a_we !== 1'b1 || a_rd !== 1'b0) begin bad++; $display("FAIL wr_strobe got=%b%b exp=10", a_we, a_rd); end
    total++; if (a_addr !== 32'h3000_0008 || a_wdata !== 32'h1B8) begin bad++; $display("FAIL wr_bus got=%h/%h exp=30000008/000001b8", a_addr, a_wdata); end
    wdata[63:32] = 32'h0000_0055;
    #1;
    total++; if (a_wdata !== 32'h55) begin bad++; $display("FAIL wr_comb got=%h exp=00000055", a_wdata); end
    req = 3'b000;
    we = 3'b000;
    step();
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 3'b100;
    we = 3'b100;
    addr[95:64] = 32'h3000_0000;
    wdata[95:64] = 32'h41;
    step();
    total++; if (a_gnt !== 3'b100 || a_we !== 1'b1) begin bad++; $display("FAIL ar_gnt got=%b/%b exp=100/1", a_gnt, a_we); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (a_gnt !== 3'b000 || a_we !== 1'b0) begin bad++; $display("FAIL ar_drop got=%b/%b exp=000/0", a_gnt, a_we); end
    total++; if (a_addr !== 32'h0) begin bad++; $display("FAIL ar_addr got=%h exp=00000000", a_addr); end
    req = 3'b000;
    we = 3'b000;
    step();
    rst_n = 1'b1;
    step();
    total++; if (a_gnt !== 3'b000 || a_we !== 1'b0) begin bad++; $display("FAIL ar_idle got=%b/%b exp=000/0", a_gnt, a_we); end
    req = 3'b100;
    step();
    total++; if (a_gnt !== 3'b100) begin bad++; $display("FAIL ar_regrant got=%b exp=100", a_gnt); end
    req = 3'b000;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_preempt();
    test_burst();
    test_rr();
    test_write();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single-cycle memory/peripheral bus (ROM, RAM, UART at 0x3000_0000) between the core data port, the UART firmware loader and the JTAG debug master.
- Uses a registered grant with round-robin rotation, a priority mask for debug masters, and a per-grant burst limit so no master is starved.
- Stalls the pipeline through hold_flag_o while the core is locked out.
- Sits between the masters and the bus decoder in the top level.

Parameters:
- N_MASTERS, 3, number of masters; index 0 is always the core.
- PRIO_MASK, 3'b110, masters whose pending request pre-empts round-robin (uart_debug = 1, jtag = 2).
- MAX_BURST, 16, maximum consecutive granted cycles while another request is pending; legal range 2..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m_req_i  in  N_MASTERS  per-master request, held for the whole access sequence
- m_we_i  in  N_MASTERS  per-master write enable
- m_addr_i  in  32*N_MASTERS  packed addresses; master k uses bits [32k+31:32k]
- m_wdata_i  in  32*N_MASTERS  packed write data
- m_gnt_o  out  N_MASTERS  one-hot grant, registered
- m_rdata_o  out  32  s_rdata_i broadcast to all masters; valid only for the granted master
- s_rd_o  out  1  bus read strobe
- s_we_o  out  1  bus write strobe
- s_addr_o  out  32  bus address
- s_wdata_o  out  32  bus write data
- s_rdata_i  in  32  bus read data, same-cycle combinational return
- hold_flag_o  out  1  pipeline stall: m_req_i[0] & ~m_gnt_o[0]

Behaviour:
Reset (asynchronous, rst_n low):
- state=IDLE, m_gnt_o=0, rr_ptr=0, burst_cnt=0.
- s_rd_o=0, s_we_o=0, s_addr_o=0, s_wdata_o=0.
- Reset asserted mid-grant drops the grant immediately; no partial write is issued after reset asserts.

States:
- IDLE
  - No grant; bus strobes 0.
  - Any m_req_i bit set -> latch the winner into m_gnt_o and go to GRANT. m_gnt_o is high the next cycle (1-cycle latency).
- GRANT (owner g)
  - Bus mux selects master g: s_addr_o=m_addr_i[g], s_wdata_o=m_wdata_i[g], s_we_o=m_req_i[g]&m_we_i[g], s_rd_o=m_req_i[g]&~m_we_i[g].
  - burst_cnt increments, saturating at MAX_BURST, only while another m_req_i bit is set; it is cleared when no other request is pending.
  - m_req_i[g] drops, OR (burst_cnt==MAX_BURST-1 and another request is pending), OR (g is not in PRIO_MASK and a PRIO_MASK master requests) -> go to SWITCH, m_gnt_o=0, rr_ptr=g+1 mod N_MASTERS.
- SWITCH
  - One dead cycle: strobes 0, address and data hold their previous value.
  - Next cycle: if any request -> GRANT with the new winner; else -> IDLE.

Winner selection:
- If any PRIO_MASK master requests, the lowest-index such master wins.
- Otherwise the first requester at or after rr_ptr, searching cyclically, wins.

Boundary conditions:
- A pre-empted or burst-limited master keeps m_req_i high and re-competes; it must tolerate m_gnt_o dropping mid-sequence and repeat its last access.
- Simultaneous owner release and new requests still pass through SWITCH; there are no back-to-back grants.
- A single requester is never burst-limited.
- A request arriving in the same cycle as the grant decision is included in the decision.

Data path:
- The data path is combinational from the grant register; there is no added read latency (s_rdata_i -> m_rdata_o is pass-through).

Decomposition:
- Shared package/include holds: state encodings (IDLE/GRANT/SWITCH, one-hot), CORE_IDX=0, UART_DBG_IDX=1, JTAG_IDX=2, and the default PRIO_MASK/MAX_BURST values.
- One natural sub-module, rr_pick, is combinational. Inputs: req vector, priority mask, pointer. Output: one-hot winner plus a valid flag. It is reusable for interrupt arbitration.

Test Plan:
- Reset and single requester: rst_n low for 3 cycles, then m_req_i=3'b001 with addr 0x0000_0010 and we=0 -> m_gnt_o=001 one cycle later; s_rd_o=1, s_addr_o=0x10, hold_flag_o low from grant onward.
- Priority pre-emption: core granted, then uart_debug raises req -> core loses grant the next cycle; 1 SWITCH cycle with strobes 0; gnt=010; hold_flag_o=1 for the whole period.
- Burst limit: core and jtag both hold req continuously, MAX_BURST=4, PRIO_MASK=0 -> grant alternates 001 (4 cycles), dead cycle, 100 (4 cycles), dead cycle, repeating.
- Round-robin fairness: all three request, PRIO_MASK=0, each releases after 2 cycles then re-requests -> grant order 0,1,2,0.
- Write path: uart_debug granted, we=1, addr 0x3000_0008, wdata 0x1B8 -> s_we_o=1, s_addr_o=0x3000_0008, s_wdata_o=0x1B8 in the same cycle.
- Async reset mid-grant: rst_n driven low between clock edges during a jtag write -> m_gnt_o=0 and s_we_o=0 immediately (before the next edge); IDLE after release.
